// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared phase codes, FSM state type and default operand width for the sequential multiplier.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // These codes are what the seven-segment decoder turns into 0/1/2/3/E.
    localparam logic [2:0] PH_IDLE = 3'b000;
    localparam logic [2:0] PH_LOAD = 3'b001;
    localparam logic [2:0] PH_BUSY = 3'b010;
    localparam logic [2:0] PH_DONE = 3'b011;
    localparam logic [2:0] PH_ERR  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = PH_IDLE,
        ST_LOAD = PH_LOAD,
        ST_BUSY = PH_BUSY,
        ST_DONE = PH_DONE
    } state_t;

endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: shift-and-add datapath (mcand/mplier/acc/cnt); optional SEQ_MULT_EARLY_TERM_EN ends once no multiplier bits remain.
module seq_mult_dp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clr,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_sum,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Next-state of the datapath: operands on load, clear on clr, one shift-and-add per step.
    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = load ? {{WIDTH{1'b0}}, a} : step ? mcand_q << 1 : mcand_q;
        mplier_d = load ? b : step ? mplier_q >> 1 : mplier_q;
        acc_d    = clr ? '0 : step ? acc_sum : acc_q;
        cnt_d    = clr ? '0 : step ? cnt_q + 1'b1 : cnt_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last     = (cnt_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
        last     = cnt_q == CW'(WIDTH - 1);
`endif
    end

    // Datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_mult_core.sv
// seq_mult_core: iterative unsigned multiplier with start/ready handshake and display phase code; SEQ_MULT_EARLY_TERM_EN enables early exit.
module seq_mult_core
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               err,
    output logic [2:0]         phase
);

    state_t             state_q, state_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               load, clr, step, last;
    logic [2*WIDTH-1:0] acc_sum;

    seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .clr     (clr),
        .step    (step),
        .a       (a),
        .b       (b),
        .acc_sum (acc_sum),
        .last    (last)
    );

    // Next-state, datapath strobes, sticky error and result capture.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        done_d    = 1'b0;
        product_d = product_q;
        load      = 1'b0;
        clr       = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                clr     = 1'b1;
                err_d   = err_q | start;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                step  = 1'b1;
                err_d = err_q | start;
                if (last) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    product_d = acc_sum;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done    = done_q;
    assign product = product_q;
    assign err     = err_q;
    assign phase   = err_q ? PH_ERR : state_q;

endmodule

// File: doc/seq_mult_core.md
Name: seq_mult_core

Overview:
- Iterative shift-and-add unsigned multiplier with a start/ready handshake.
- Directly upstream of the seven-segment status decoder: it produces the 3-bit phase code that the decoder turns into the digits 0/1/2/3, or "E" for any other code.
- Lives in the top-level multiplier design between the operand switches/registers and the display.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..16. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to multiply; sampled every rising edge.
- a  input  WIDTH  multiplicand; captured on the accept edge.
- b  input  WIDTH  multiplier; captured on the accept edge.
- ready  output  1  high in IDLE or DONE; a start is accepted only while ready=1.
- done  output  1  one-cycle pulse in the first cycle of DONE.
- product  output  2*WIDTH  result; held stable from entry to DONE until the next accept.
- err  output  1  sticky protocol-violation flag.
- phase  output  3  status code for the seven-segment decoder.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0, product=0, err=0, phase=3'b000.
  - All datapath registers cleared.
  - Reset mid-operation aborts the operation immediately; no done pulse is produced.
- States and phase codes: IDLE=000, LOAD=001, BUSY=010, DONE=011.
- phase = err ? 3'b100 : state code, so the display shows "E" while err=1.
- Accept:
  - Occurs at a rising edge with start=1 and state in {IDLE, DONE}.
  - Captures a into mcand (zero-extended to 2*WIDTH) and b into mplier.
  - Clears err and goes to LOAD.
- LOAD (exactly 1 cycle): clears acc and cnt, then goes to BUSY.
- BUSY, per edge:
  - If mplier[0]=1, acc <= acc + mcand, computed modulo 2^(2*WIDTH). No overflow is possible.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - Leaves for DONE on the edge where cnt==WIDTH-1.
  - On that same edge, product <= final acc.
- DONE:
  - done=1 for the first DONE cycle only.
  - Remains in DONE until the next accept.
  - A start in DONE re-accepts directly, with LOAD on the following cycle.
- Latency: done rises WIDTH+1 cycles after the accept edge (9 for WIDTH=8).
- Throughput: one operation per WIDTH+2 cycles when start is held continuously.
- start=1 while in LOAD or BUSY:
  - Operation continues unaffected and the operands are ignored.
  - err <= 1, sticky until the next accept or reset.
- start held high through DONE: accepted on the first DONE edge, so DONE lasts a single cycle and done still pulses.
- a=0 or b=0: the full iteration count still runs; product=0.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - BUSY also exits to DONE on any edge where (mplier>>1)==0 after that edge's add.
  - Latency becomes 1 + max(1, bit length of b) cycles.
  - For b=0 or b=1 the latency is 2.
- Undefined: fixed WIDTH+1 latency as above; no extra logic.

Decomposition:
- Shared header/package seq_mult_pkg holds:
  - state/phase localparams PH_IDLE, PH_LOAD, PH_BUSY, PH_DONE, PH_ERR=3'b100;
  - the default WIDTH constant.
- The phase encodings there are the single source of truth for the seven-segment decoder.
- One natural sub-module, seq_mult_dp:
  - mcand/mplier/acc/cnt registers plus the adder;
  - controlled by load and step strobes from the FSM in seq_mult_core.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: a=13, b=11 accepted, rst_n pulsed low 4 cycles later.
  - Response: outputs return to reset values asynchronously; phase=000; no done pulse.
- Basic multiply, WIDTH=8, macro off:
  - Stimulus: a=13, b=11.
  - Response: done exactly 9 cycles after accept; product=16'h008F; phase sequence 001, 010×8, 011.
- Max operands:
  - Stimulus: a=255, b=255.
  - Response: product=16'hFE01; held through 5 idle cycles in DONE.
- Protocol violation:
  - Stimulus: start pulsed during BUSY with a=2, b=2, during a 7×6 operation.
  - Response: product=42; err=1 and phase=100 from the edge after the violating start; both clear on the next accept.
- Back-to-back: start held high with a=3, b=5.
  - Response: product=15 at each done.
  - Response: done pulses every 10 cycles.
  - Response: ready=1 only in the DONE cycles.
- SEQ_MULT_EARLY_TERM_EN defined:
  - Stimulus: b=0, then b=1, then b=13, each with a=9.
  - Response: done at 2, 2 and 5 cycles after accept; products 0, 9 and 117.
